// File: rtl/mem_writer.sv
// Streams DEPTH words from a valid/ready source into consecutive memory addresses.
// Define MEM_WRITER_VERIFY_EN to add a readback pass that compares 8-bit checksums.
module mem_writer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              read,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] d_out,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              error
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
`ifdef MEM_WRITER_VERIFY_EN
        VERIFY = 2'd2,
`endif
        FINISH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              load_begin;
    logic              load_hs;

    assign load_begin = (state_q == IDLE) && start;
    assign load_hs    = (state_q == LOAD) && in_valid;

`ifdef MEM_WRITER_VERIFY_EN
    logic verify_last;
`endif

    // The low bits of count double as the write pointer; count never exceeds DEPTH.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (load_begin) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (load_hs) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[ADDR_W-1:0];
                    wr_data_d = in_data;
                    count_d   = count_q + CNT_W'(1);
                    if (count_q[ADDR_W-1:0] == LAST_PTR) begin
`ifdef MEM_WRITER_VERIFY_EN
                        state_d = VERIFY;
`else
                        state_d = FINISH;
`endif
                    end
                end
            end
`ifdef MEM_WRITER_VERIFY_EN
            VERIFY: begin
                if (verify_last) begin
                    state_d = FINISH;
                end
            end
`endif
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
    assign count    = count_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

`ifdef MEM_WRITER_VERIFY_EN
    logic [7:0]       wsum_q, wsum_d;
    logic [7:0]       rsum_q, rsum_d;
    logic [7:0]       rsum_next;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             error_q, error_d;
    logic             read_int;

    // vcnt counts VERIFY cycles: reads issue on 0..DEPTH-1, captures land on 1..DEPTH.
    assign verify_last = (state_q == VERIFY) && (vcnt_q == DEPTH_C);
    assign read_int    = (state_q == VERIFY) && (vcnt_q != DEPTH_C);
    assign rsum_next   = rsum_q + 8'(d_out);

    always_comb begin
        wsum_d  = wsum_q;
        rsum_d  = rsum_q;
        vcnt_d  = vcnt_q;
        error_d = error_q;
        if (load_begin) begin
            wsum_d  = '0;
            rsum_d  = '0;
            vcnt_d  = '0;
            error_d = 1'b0;
        end
        if (load_hs) begin
            wsum_d = wsum_q + 8'(in_data);
        end
        if (state_q == VERIFY) begin
            vcnt_d = vcnt_q + CNT_W'(1);
            if (vcnt_q != '0) begin
                rsum_d = rsum_next;
            end
            if (verify_last) begin
                error_d = (rsum_next != wsum_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wsum_q  <= '0;
            rsum_q  <= '0;
            vcnt_q  <= '0;
            error_q <= 1'b0;
        end else begin
            wsum_q  <= wsum_d;
            rsum_q  <= rsum_d;
            vcnt_q  <= vcnt_d;
            error_q <= error_d;
        end
    end

    assign read    = read_int;
    assign address = read_int ? vcnt_q[ADDR_W-1:0] : '0;
    assign error   = error_q;
`else
    logic unused_d_out;
    assign unused_d_out = ^d_out;
    assign read    = 1'b0;
    assign address = '0;
    assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_writer.sv
// Randomized bench for mem_writer: per-cycle traces are compared with a reference
// built from the load/verify rules, and a memory model checks what actually got written.
module tb_mem_writer;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;
    localparam int MAXC   = 256;
    localparam int VW     = 3 * ADDR_W + DATA_W + 7;
`ifdef MEM_WRITER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] d_out;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              error;

    int checks = 0;
    int errors = 0;

    mem_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .read(read), .address(address), .d_out(d_out), .busy(busy), .done(done),
        .count(count), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered write, 1-cycle read latency, optional stuck read at address 3.
    logic [DATA_W-1:0] mem [2**ADDR_W];
    bit fault3;
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (read) d_out <= (fault3 && address == ADDR_W'(3)) ? '0 : mem[address];
    end

    bit                s_valid [MAXC];
    bit                s_start [MAXC];
    bit                s_rst   [MAXC];
    logic [DATA_W-1:0] s_data  [MAXC];
    logic [DATA_W-1:0] words   [DEPTH];
    logic [VW-1:0]     e_vec   [MAXC];
    logic [VW-1:0]     e_msk   [MAXC];
    logic [VW-1:0]     o_vec   [MAXC];
    logic [DATA_W-1:0] exp_mem [DEPTH];
    bit                exp_known [DEPTH];
    int m_len, m_acc, m_done_c;

    task automatic clear_stim();
        for (int t = 0; t < MAXC; t++) begin
            s_valid[t] = 1'b0;
            s_start[t] = 1'b0;
            s_rst[t]   = 1'b0;
        end
    endtask

    // Reference: cycle 0 is the start pulse; words are accepted in order on valid cycles
    // while loading; each accepted word appears on the write port one cycle later.
    task automatic build_model(input bit fault);
        int acc, last, abort, done_c, cnt, wsum, rsum;
        bit err, ir, we, rd, by, dn, er, chk;
        bit hs [MAXC];
        int hidx [MAXC];
        logic [ADDR_W-1:0] wa, ad;
        logic [DATA_W-1:0] wd;
        logic [ADDR_W:0]   cv;
        acc = 0; last = -1; abort = -1;
        for (int t = 0; t < MAXC; t++) begin
            hs[t] = 1'b0;
            hidx[t] = 0;
            if (t >= 1 && abort < 0 && s_rst[t]) abort = t;
            s_data[t] = words[(acc < DEPTH) ? acc : DEPTH - 1];
            if (t >= 1 && abort < 0 && acc < DEPTH && s_valid[t]) begin
                hs[t] = 1'b1;
                hidx[t] = acc;
                acc++;
                if (acc == DEPTH) last = t;
            end
        end
        wsum = 0; rsum = 0;
        for (int a = 0; a < DEPTH; a++) begin
            wsum += int'(words[a]);
            rsum += (fault && a == 3) ? 0 : int'(words[a]);
        end
        err = VER && ((wsum % 256) != (rsum % 256));
        done_c = (last < 0 || abort >= 0) ? -1 : (VER ? last + DEPTH + 2 : last + 1);
        cnt = 0;
        for (int t = 0; t < MAXC; t++) begin
            chk = (t >= 1);
            if (abort >= 0 && t > abort) begin
                e_vec[t] = '0;
                e_msk[t] = '1;
            end else begin
                ir = (t >= 1) && (last < 0 || t <= last);
                we = (t >= 1) ? hs[t-1] : 1'b0;
                wa = we ? ADDR_W'(hidx[t-1]) : '0;
                wd = we ? words[hidx[t-1]] : '0;
                rd = VER && last >= 0 && t >= last + 1 && t <= last + DEPTH;
                ad = rd ? ADDR_W'(t - last - 1) : '0;
                by = (t >= 1) && (done_c < 0 || t <= done_c);
                dn = (t == done_c);
                cv = (ADDR_W + 1)'(cnt);
                er = (done_c >= 0 && t >= done_c) ? err : 1'b0;
                e_vec[t] = {ir, we, wa, wd, rd, ad, by, dn, cv, er};
                e_msk[t] = {1'b1, 1'b1, {ADDR_W{we}}, {DATA_W{we}}, 1'b1, {ADDR_W{1'b1}},
                            1'b1, 1'b1, {(ADDR_W + 1){chk}}, chk};
            end
            if (hs[t]) cnt++;
        end
        m_len    = (done_c >= 0) ? done_c + 3 : ((abort >= 0) ? abort + 6 : MAXC);
        m_acc    = acc;
        m_done_c = done_c;
        for (int k = 0; k < acc; k++) begin
            exp_mem[k]   = words[k];
            exp_known[k] = 1'b1;
        end
    endtask

    task automatic drive_run();
        for (int t = 0; t < m_len; t++) begin
            o_vec[t] = {in_ready, wr_en, wr_addr, wr_data, read, address, busy, done, count, error};
            start    = (t == 0) || s_start[t];
            rst      = s_rst[t];
            in_valid = s_valid[t];
            in_data  = s_data[t];
            @(posedge clk); #1;
        end
        start = 1'b0; rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic int done_pulses();
        int n = 0;
        for (int t = 0; t < m_len; t++) if (o_vec[t][ADDR_W + 2] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, read, address, busy, done, count, error} !== '0) begin
            errors++;
            $display("FAIL reset_state got %h expected 0",
                     {in_ready, wr_en, wr_addr, wr_data, read, address, busy, done, count, error});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data = DATA_W'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({in_ready, wr_en, busy, done} !== 4'b0) begin
                errors++;
                $display("FAIL idle_no_start cycle %0d got %b expected 0000", i, {in_ready, wr_en, busy, done});
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        $display("test_reset: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_full_load();
        clear_stim();
        for (int k = 0; k < DEPTH; k++) words[k] = DATA_W'(k);
        for (int t = 0; t < MAXC; t++) s_valid[t] = 1'b1;
        build_model(1'b0);
        drive_run();
        for (int t = 0; t < m_len; t++) begin
            checks++;
            if ((o_vec[t] & e_msk[t]) !== (e_vec[t] & e_msk[t])) begin
                errors++;
                $display("FAIL full_load t=%0d got %h expected %h mask %h", t, o_vec[t], e_vec[t], e_msk[t]);
            end
        end
        checks++;
        if (done_pulses() !== 1) begin
            errors++;
            $display("FAIL full_load_done_count got %0d expected 1", done_pulses());
        end
        checks++;
        if (count !== (ADDR_W + 1)'(DEPTH)) begin
            errors++;
            $display("FAIL full_load_count_hold got %0d expected %0d", count, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) begin
            if (exp_known[a]) begin
                checks++;
                if (mem[a] !== exp_mem[a]) begin
                    errors++;
                    $display("FAIL full_load_mem addr %0d got %h expected %h", a, mem[a], exp_mem[a]);
                end
            end
        end
        $display("test_full_load: done_cycle=%0d checks=%0d errors=%0d", m_done_c, checks, errors);
    endtask

    task automatic test_stalled();
        clear_stim();
        for (int k = 0; k < DEPTH; k++) words[k] = (k % 2 == 0) ? 4'hA : 4'h5;
        for (int t = 0; t < MAXC; t++) s_valid[t] = (t >= 1) && ((t - 1) % 3 == 0);
        build_model(1'b0);
        drive_run();
        for (int t = 0; t < m_len; t++) begin
            checks++;
            if ((o_vec[t] & e_msk[t]) !== (e_vec[t] & e_msk[t])) begin
                errors++;
                $display("FAIL stalled t=%0d got %h expected %h mask %h", t, o_vec[t], e_vec[t], e_msk[t]);
            end
        end
        checks++;
        if (done_pulses() !== 1) begin
            errors++;
            $display("FAIL stalled_done_count got %0d expected 1", done_pulses());
        end
        for (int a = 0; a < DEPTH; a++) begin
            checks++;
            if (mem[a] !== exp_mem[a]) begin
                errors++;
                $display("FAIL stalled_mem addr %0d got %h expected %h", a, mem[a], exp_mem[a]);
            end
        end
        $display("test_stalled: done_cycle=%0d checks=%0d errors=%0d", m_done_c, checks, errors);
    endtask

    task automatic test_random_loads();
        for (int it = 0; it < 3; it++) begin
            clear_stim();
            for (int k = 0; k < DEPTH; k++) words[k] = DATA_W'($urandom);
            for (int t = 0; t < MAXC; t++) s_valid[t] = (t >= 100) || ($urandom_range(0, 99) < 65);
            build_model(1'b0);
            drive_run();
            for (int t = 0; t < m_len; t++) begin
                checks++;
                if ((o_vec[t] & e_msk[t]) !== (e_vec[t] & e_msk[t])) begin
                    errors++;
                    $display("FAIL random_load%0d t=%0d got %h expected %h mask %h", it, t, o_vec[t], e_vec[t], e_msk[t]);
                end
            end
            checks++;
            if (done_pulses() !== 1) begin
                errors++;
                $display("FAIL random_load%0d_done_count got %0d expected 1", it, done_pulses());
            end
            for (int a = 0; a < DEPTH; a++) begin
                checks++;
                if (mem[a] !== exp_mem[a]) begin
                    errors++;
                    $display("FAIL random_load%0d_mem addr %0d got %h expected %h", it, a, mem[a], exp_mem[a]);
                end
            end
            $display("test_random_loads[%0d]: done_cycle=%0d checks=%0d errors=%0d", it, m_done_c, checks, errors);
        end
    endtask

    task automatic test_start_ignored();
        clear_stim();
        for (int k = 0; k < DEPTH; k++) words[k] = DATA_W'($urandom);
        for (int t = 0; t < MAXC; t++) s_valid[t] = 1'b1;
        s_start[6] = 1'b1;  // word 5 is offered in cycle 6
        build_model(1'b0);
        drive_run();
        for (int t = 0; t < m_len; t++) begin
            checks++;
            if ((o_vec[t] & e_msk[t]) !== (e_vec[t] & e_msk[t])) begin
                errors++;
                $display("FAIL start_ignored t=%0d got %h expected %h mask %h", t, o_vec[t], e_vec[t], e_msk[t]);
            end
        end
        checks++;
        if (count !== (ADDR_W + 1)'(DEPTH)) begin
            errors++;
            $display("FAIL start_ignored_count got %0d expected %0d", count, DEPTH);
        end
        $display("test_start_ignored: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_abort();
        clear_stim();
        for (int k = 0; k < DEPTH; k++) words[k] = ~exp_mem[k];
        for (int t = 0; t < MAXC; t++) s_valid[t] = 1'b1;
        s_rst[9] = 1'b1;  // word 8 is offered in cycle 9
        build_model(1'b0);
        drive_run();
        for (int t = 0; t < m_len; t++) begin
            checks++;
            if ((o_vec[t] & e_msk[t]) !== (e_vec[t] & e_msk[t])) begin
                errors++;
                $display("FAIL reset_abort t=%0d got %h expected %h mask %h", t, o_vec[t], e_vec[t], e_msk[t]);
            end
        end
        checks++;
        if (done_pulses() !== 0) begin
            errors++;
            $display("FAIL reset_abort_done_count got %0d expected 0", done_pulses());
        end
        for (int a = 0; a < DEPTH; a++) begin
            checks++;
            if (mem[a] !== exp_mem[a]) begin
                errors++;
                $display("FAIL reset_abort_mem addr %0d got %h expected %h", a, mem[a], exp_mem[a]);
            end
        end
        $display("test_reset_abort: words_written=%0d checks=%0d errors=%0d", m_acc, checks, errors);
    endtask

    task automatic test_verify();
        for (int pass = 0; pass < 3; pass++) begin
            clear_stim();
            for (int k = 0; k < DEPTH; k++) words[k] = (pass == 2) ? DATA_W'($urandom) : DATA_W'(k);
            for (int t = 0; t < MAXC; t++) s_valid[t] = 1'b1;
            fault3 = (pass == 1);
            build_model(fault3);
            drive_run();
            for (int t = 0; t < m_len; t++) begin
                checks++;
                if ((o_vec[t] & e_msk[t]) !== (e_vec[t] & e_msk[t])) begin
                    errors++;
                    $display("FAIL verify%0d t=%0d got %h expected %h mask %h", pass, t, o_vec[t], e_vec[t], e_msk[t]);
                end
            end
            checks++;
            if (o_vec[m_done_c][0] !== (VER && pass == 1)) begin
                errors++;
                $display("FAIL verify%0d_error_at_done got %b expected %b", pass, o_vec[m_done_c][0], VER && pass == 1);
            end
            checks++;
            if (done_pulses() !== 1) begin
                errors++;
                $display("FAIL verify%0d_done_count got %0d expected 1", pass, done_pulses());
            end
            $display("test_verify[%0d]: fault=%0d done_cycle=%0d checks=%0d errors=%0d",
                     pass, fault3, m_done_c, checks, errors);
        end
        fault3 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; fault3 = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            exp_known[a] = 1'b0;
            exp_mem[a]   = '0;
        end
        test_reset();
        test_full_load();
        test_stalled();
        test_random_loads();
        test_start_ignored();
        test_reset_abort();
        test_verify();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_writer.md
Name: mem_writer

Overview:
- Write-side counterpart of the 16x4 ROM/memory read interface (`clk`, `read`, `address`, `d_out`).
- Accepts a valid/ready stream of data words and writes them to consecutive addresses, 0 to DEPTH-1, through a registered write port.
- Raises `done` when the last word is written.
- Used to program the memory model before read-side sweeps. The optional readback pass re-reads the memory and checks an 8-bit checksum.

Parameters:
- ADDR_W, 4, address width.
- DATA_W, 4, data word width.
- DEPTH, 16, number of words per load; must be <= 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins a load when IDLE
- in_valid  input  1  upstream data valid
- in_data  input  DATA_W  upstream data word
- in_ready  output  1  block accepts in_data this cycle
- wr_en  output  1  memory write strobe
- wr_addr  output  ADDR_W  memory write address
- wr_data  output  DATA_W  memory write data
- read  output  1  memory read enable (readback)
- address  output  ADDR_W  memory read address (readback)
- d_out  input  DATA_W  memory read data, valid 1 cycle after read/address sampled
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse at end of load (and readback if enabled)
- count  output  ADDR_W+1  words written so far in current load
- error  output  1  checksum mismatch flag; sticky until next start

Behaviour:
- Reset (`rst`=1 at posedge) values:
  - state=IDLE.
  - `in_ready`, `wr_en`, `read`, `busy`, `done`, `error` = 0.
  - `wr_addr`, `wr_data`, `address`, `count` = 0.
  - Internal checksums = 0.
- Reset mid-load or mid-readback aborts immediately. Partial writes stay in memory; no `done`.
- States: IDLE, LOAD, VERIFY (only with macro), FINISH.
- IDLE:
  - `in_ready`=0.
  - `start`=1 -> LOAD. Clears `count`, write address pointer, `error`, and checksums.
- LOAD:
  - `in_ready`=1 combinationally while in LOAD.
  - Handshake = `in_valid` & `in_ready` at posedge.
  - On handshake, the next cycle presents `wr_en`=1, `wr_addr`=pointer, `wr_data`=`in_data` (write latency 1).
  - Pointer and `count` increment on the same handshake edge.
  - `wr_en`=0 in any cycle following a non-handshake cycle.
  - `in_valid`=0 stalls indefinitely; no timeout.
  - Write checksum: wsum <= wsum + in_data, 8-bit, wrapping modulo 256.
  - Handshake on pointer = DEPTH-1 -> VERIFY (macro) else FINISH.
  - `in_ready` drops the cycle after the last handshake.
- FINISH:
  - `done`=1 for exactly one cycle, then IDLE.
  - `count` holds DEPTH until next start.
  - `wr_en` for the last word and `done` are asserted in the same cycle.
- `start` while not IDLE is ignored.
- Address wrap: pointer never exceeds DEPTH-1. With DEPTH < 2**ADDR_W, upper addresses are untouched.
- `busy`=1 in LOAD, VERIFY and FINISH.

Optional Feature:
- Macro: MEM_WRITER_VERIFY_EN.
- Defined:
  - After LOAD, enter VERIFY.
  - Drive `read`=1 with `address` = 0..DEPTH-1, one address per cycle.
  - Capture `d_out` one cycle after each address: rsum <= rsum + d_out, 8-bit.
  - After the DEPTH-th capture, `read`=0; `error` <= (rsum != wsum); then FINISH.
  - VERIFY lasts DEPTH+1 cycles.
- Not defined:
  - VERIFY state absent; `read`=0 and `address`=0 constantly; `d_out` ignored.
  - `error` is constant 0.
  - Checksum logic is not synthesised.

Test Plan:
- Reset then idle: `rst` high 2 cycles -> all outputs 0; `in_valid`=1 without `start` -> `in_ready` stays 0, no `wr_en`.
- Full load: `start`, then 16 back-to-back words 0..15 with `in_valid`=1 -> `wr_en` on 16 consecutive cycles, `wr_addr`=0..15, `wr_data`=addr; `done` pulse aligned with addr 15 write (no macro); `count`=16.
- Stalled upstream: `in_valid` toggled 1,0,0,1,... with data 0xA,0x5 repeating -> writes only after handshakes; `wr_addr` strictly sequential; total 16 writes; `done` once.
- Start ignored / reset abort: `start` pulse at word 5 -> no restart, `count` continues to 16. Separate run: `rst` at word 8 -> IDLE, `count`=0, no `done`.
- Verify pass (macro): load data 0..15 (wsum=120) into a 1-cycle-latency memory model -> `read` high 16 cycles, addresses 0..15, `error`=0, `done` pulses.
- Verify fail (macro): memory model forces addr 3 to read 0x0 after writing 0x3 -> rsum=117 != 120 -> `error`=1 with `done`; `error` clears on next `start`.
